// File: rtl/branch_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// branch_ctrl_pkg
//   Shared types and constants for the branch prediction / redirect controller.
//   Holds the FSM state encoding, the 2-bit saturating counter codes and a
//   helper that computes the next counter value from a resolved direction.
// ----------------------------------------------------------------------------
package branch_ctrl_pkg;

  // Default BTB index width (16 entries)
  localparam int BTB_IDX_W = 4;

  // Redirect FSM state encoding
  typedef enum logic {
    BC_ST_IDLE  = 1'b0,
    BC_ST_REDIR = 1'b1
  } bc_state_e;

  // 2-bit direction counter; the MSB is the taken prediction
  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'b00;
  localparam ctr_t CTR_WNT = 2'b01;
  localparam ctr_t CTR_WT  = 2'b10;
  localparam ctr_t CTR_ST  = 2'b11;

  // Saturating increment on taken, saturating decrement on not-taken
  function automatic ctr_t ctr_update(input ctr_t cur, input logic taken);
    ctr_t nxt;
    nxt = cur;
    if (taken) begin
      if (cur != CTR_ST) nxt = cur + 2'd1;
    end else begin
      if (cur != CTR_SNT) nxt = cur - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_ctrl_btb_array.sv
// ----------------------------------------------------------------------------
// branch_ctrl_btb_array
//   Direct-mapped BTB storage: valid, uncond, ctr, tag and target per entry.
//   Two asynchronous read ports (fetch lookup and EX-side hit check), one
//   synchronous write port that fills a whole entry, and a synchronous valid
//   clear. A write and a clear never coincide; write wins if they do.
// Ports
//   clk, rst          clock, synchronous active-high reset
//   if_idx / if_*     fetch-side read port
//   ex_idx / ex_*     EX-side read port
//   wr_*              entry write (sets valid)
//   clr_en, clr_idx   valid clear
// ----------------------------------------------------------------------------
module branch_ctrl_btb_array
  import branch_ctrl_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4,
  parameter int TAG_W   = 26,
  parameter int PC_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] if_idx,
  output logic             if_valid,
  output logic             if_uncond,
  output ctr_t             if_ctr,
  output logic [TAG_W-1:0] if_tag,
  output logic [PC_W-1:0]  if_tgt,
  input  logic [IDX_W-1:0] ex_idx,
  output logic             ex_valid,
  output logic             ex_uncond,
  output ctr_t             ex_ctr,
  output logic [TAG_W-1:0] ex_tag,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [PC_W-1:0]  wr_tgt,
  input  logic             wr_uncond,
  input  ctr_t             wr_ctr,
  input  logic             clr_en,
  input  logic [IDX_W-1:0] clr_idx
);

  logic             valid_q  [ENTRIES];
  ctr_t             ctr_q    [ENTRIES];
  logic             uncond_q [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [PC_W-1:0]  tgt_q    [ENTRIES];

  // Reads are combinational so a same-cycle write is not yet visible
  assign if_valid  = valid_q[if_idx];
  assign if_uncond = uncond_q[if_idx];
  assign if_ctr    = ctr_q[if_idx];
  assign if_tag    = tag_q[if_idx];
  assign if_tgt    = tgt_q[if_idx];

  assign ex_valid  = valid_q[ex_idx];
  assign ex_uncond = uncond_q[ex_idx];
  assign ex_ctr    = ctr_q[ex_idx];
  assign ex_tag    = tag_q[ex_idx];

  // Valid and counter state: reset to empty / weakly-not-taken
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_WNT;
      end
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
      ctr_q[wr_idx]   <= wr_ctr;
    end else if (clr_en) begin
      valid_q[clr_idx] <= 1'b0;
    end
  end

  // Payload fields are only meaningful under valid, so they carry no reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      uncond_q[wr_idx] <= wr_uncond;
      tag_q[wr_idx]    <= wr_tag;
      tgt_q[wr_idx]    <= wr_tgt;
    end
  end

endmodule

// File: rtl/branch_ctrl.sv
// ----------------------------------------------------------------------------
// branch_ctrl
//   Branch prediction and redirect controller between IF and EX.
//   Fetch gets a zero-latency BTB prediction for if_pc. When EX resolves an
//   instruction the BTB is trained, mispredicts are detected, IF/ID is flushed
//   and a corrected PC is offered to fetch through a valid/ready handshake.
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   if_pc -> if_pred_taken/target  fetch-side prediction (combinational)
//   ex_*                           resolved instruction from EX
//   flush                          kill IF/ID, bubble into ID/EX
//   redirect_valid/pc/ready        corrected-PC handshake to fetch
//   stat_branches/mispredicts      free-running 32-bit event counters
// ----------------------------------------------------------------------------
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int BTB_ENTRIES = 16,
  parameter int PC_W        = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] if_pc,
  output logic            if_pred_taken,
  output logic [PC_W-1:0] if_pred_target,
  input  logic            ex_valid,
  input  logic            ex_stall,
  input  logic [PC_W-1:0] ex_pc,
  input  logic [PC_W-1:0] ex_npc,
  input  logic            ex_pred_taken,
  input  logic [PC_W-1:0] ex_pred_target,
  input  logic            ex_is_branch,
  input  logic            ex_is_cond,
  input  logic            ex_is_taken,
  input  logic [PC_W-1:0] ex_target,
  output logic            flush,
  output logic            redirect_valid,
  output logic [PC_W-1:0] redirect_pc,
  input  logic            redirect_ready,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;

  bc_state_e state;

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic             if_e_valid, if_e_uncond;
  ctr_t             if_e_ctr;
  logic [TAG_W-1:0] if_e_tag;
  logic [PC_W-1:0]  if_e_tgt;
  logic             ex_e_valid, ex_e_uncond;
  ctr_t             ex_e_ctr;
  logic [TAG_W-1:0] ex_e_tag;

  logic             wr_en, clr_en, wr_uncond;
  ctr_t             wr_ctr;

  logic             fire, if_hit, ex_hit, actual_taken, mispredict;
  logic [PC_W-1:0]  actual_npc;

  // Instruction bytes offsets are always zero and carry no information
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[PC_W-1:IDX_W+2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[PC_W-1:IDX_W+2];

  branch_ctrl_btb_array #(
    .ENTRIES (BTB_ENTRIES),
    .IDX_W   (IDX_W),
    .TAG_W   (TAG_W),
    .PC_W    (PC_W)
  ) u_btb (
    .clk       (clk),
    .rst       (rst),
    .if_idx    (if_idx),
    .if_valid  (if_e_valid),
    .if_uncond (if_e_uncond),
    .if_ctr    (if_e_ctr),
    .if_tag    (if_e_tag),
    .if_tgt    (if_e_tgt),
    .ex_idx    (ex_idx),
    .ex_valid  (ex_e_valid),
    .ex_uncond (ex_e_uncond),
    .ex_ctr    (ex_e_ctr),
    .ex_tag    (ex_e_tag),
    .wr_en     (wr_en),
    .wr_idx    (ex_idx),
    .wr_tag    (ex_tag),
    .wr_tgt    (ex_target),
    .wr_uncond (wr_uncond),
    .wr_ctr    (wr_ctr),
    .clr_en    (clr_en),
    .clr_idx   (ex_idx)
  );

  // Fetch-side prediction: jumps always predict taken, BEQs follow ctr MSB
  assign if_hit         = if_e_valid & (if_e_tag == if_tag);
  assign if_pred_taken  = if_hit & (if_e_uncond | if_e_ctr[1]);
  assign if_pred_target = if_e_tgt;

  // Resolution; a non-branch can never be taken, whatever ex_is_taken says
  assign fire         = ex_valid & ~ex_stall;
  assign ex_hit       = ex_e_valid & (ex_e_tag == ex_tag);
  assign actual_taken = ex_is_branch & ex_is_taken;
  assign actual_npc   = actual_taken ? ex_target : ex_npc;
  assign mispredict   = fire & ((ex_pred_taken != actual_taken) |
                                (ex_pred_taken & (ex_pred_target != ex_target)));

  // Table training: hits retrain, taken misses allocate, aliased
  // non-branch hits are invalidated so they stop steering fetch
  always_comb begin
    wr_en     = 1'b0;
    clr_en    = 1'b0;
    wr_ctr    = CTR_WT;
    wr_uncond = ~ex_is_cond;
    if (fire & ex_is_branch) begin
      if (ex_hit) begin
        wr_en     = 1'b1;
        wr_ctr    = ctr_update(ex_e_ctr, actual_taken);
        wr_uncond = ex_e_uncond;
      end else if (actual_taken) begin
        wr_en = 1'b1;
      end
    end else if (fire & ex_hit) begin
      clr_en = 1'b1;
    end
  end

  // Redirect FSM: capture the corrected PC on a mispredict and hold it
  // until fetch accepts; mispredicts seen while redirecting are ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BC_ST_IDLE;
      redirect_pc <= '0;
    end else begin
      case (state)
        BC_ST_IDLE: begin
          if (mispredict) begin
            state       <= BC_ST_REDIR;
            redirect_pc <= actual_npc;
          end
        end
        BC_ST_REDIR: begin
          if (redirect_ready) state <= BC_ST_IDLE;
        end
        default: state <= BC_ST_IDLE;
      endcase
    end
  end

  assign redirect_valid = (state == BC_ST_REDIR);
  // Flush must hit IF/ID in the very cycle the mispredict resolves
  assign flush = (state == BC_ST_REDIR) | ((state == BC_ST_IDLE) & mispredict);

  // Event counters, wrap at 32 bits
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (fire & ex_is_branch) stat_branches <= stat_branches + 32'd1;
      if (mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// ----------------------------------------------------------------------------
// tb_branch_ctrl
//   Scenario-driven bench for branch_ctrl. Expected redirect PCs are queued
//   when a mispredicting instruction is driven and popped when fetch sees
//   redirect_valid.
// ----------------------------------------------------------------------------
module tb_branch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic [31:0] if_pred_target;
  logic        ex_valid, ex_stall;
  logic [31:0] ex_pc, ex_npc, ex_pred_target, ex_target;
  logic        ex_pred_taken, ex_is_branch, ex_is_cond, ex_is_taken;
  logic        flush, redirect_valid, redirect_ready;
  logic [31:0] redirect_pc;
  logic [31:0] stat_branches, stat_mispredicts;

  int checks = 0;
  int errors = 0;
  int exp_branches = 0;
  int exp_mispredicts = 0;
  logic [31:0] exp_redir_q[$];

  branch_ctrl #(.BTB_ENTRIES(16), .PC_W(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .if_pc            (if_pc),
    .if_pred_taken    (if_pred_taken),
    .if_pred_target   (if_pred_target),
    .ex_valid         (ex_valid),
    .ex_stall         (ex_stall),
    .ex_pc            (ex_pc),
    .ex_npc           (ex_npc),
    .ex_pred_taken    (ex_pred_taken),
    .ex_pred_target   (ex_pred_target),
    .ex_is_branch     (ex_is_branch),
    .ex_is_cond       (ex_is_cond),
    .ex_is_taken      (ex_is_taken),
    .ex_target        (ex_target),
    .flush            (flush),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .redirect_ready   (redirect_ready),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );

  always #5 clk = ~clk;

  // Hard stop in case a scenario wedges
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic idle_ex();
    ex_valid       = 1'b0;
    ex_stall       = 1'b0;
    ex_pc          = '0;
    ex_npc         = 32'd4;
    ex_pred_taken  = 1'b0;
    ex_pred_target = '0;
    ex_is_branch   = 1'b0;
    ex_is_cond     = 1'b0;
    ex_is_taken    = 1'b0;
    ex_target      = '0;
  endtask

  // Drive one resolving instruction for a single cycle; starts and ends
  // just after a rising edge. flush is sampled before the edge.
  task automatic resolve(input logic [31:0] pc, input logic pt, input logic [31:0] ptgt,
                         input logic br, input logic cond, input logic tk,
                         input logic [31:0] tgt, input logic exp_mp, output logic fl);
    ex_valid       = 1'b1;
    ex_stall       = 1'b0;
    ex_pc          = pc;
    ex_npc         = pc + 32'd4;
    ex_pred_taken  = pt;
    ex_pred_target = ptgt;
    ex_is_branch   = br;
    ex_is_cond     = cond;
    ex_is_taken    = tk;
    ex_target      = tgt;
    if (exp_mp) begin
      exp_redir_q.push_back(tk ? tgt : pc + 32'd4);
      exp_mispredicts++;
    end
    if (br) exp_branches++;
    #2 fl = flush;
    @(posedge clk);
    #1;
    idle_ex();
  endtask

  // Bounded wait for redirect_valid; reports how many extra cycles it took
  task automatic wait_redirect(output int waited);
    waited = 0;
    while (!redirect_valid && waited < 8) begin
      @(posedge clk);
      #1;
      waited++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    redirect_ready = 1'b1;
    idle_ex();
    if_pc = 32'h40;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (flush !== 1'b0) begin errors++; $display("[TB] FAIL reset_flush: got %b want 0", flush); end
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rvalid: got %b want 0", redirect_valid); end
    checks++; if (redirect_pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_rpc: got %h want 0", redirect_pc); end
    checks++; if (stat_branches !== 32'd0) begin errors++; $display("[TB] FAIL reset_branches: got %0d want 0", stat_branches); end
    checks++; if (stat_mispredicts !== 32'd0) begin errors++; $display("[TB] FAIL reset_mispredicts: got %0d want 0", stat_mispredicts); end
    checks++; if (if_pred_taken !== 1'b0) begin errors++; $display("[TB] FAIL reset_pred: got %b want 0", if_pred_taken); end
  endtask

  task automatic test_cold_jump();
    logic fl;
    int w;
    logic [31:0] exp_pc;
    if_pc = 32'h40;
    #1;
    checks++; if (if_pred_taken !== 1'b0) begin errors++; $display("[TB] FAIL cold_pred: got %b want 0", if_pred_taken); end
    resolve(32'h40, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h100, 1'b1, fl);
    checks++; if (fl !== 1'b1) begin errors++; $display("[TB] FAIL cold_flush_same_cycle: got %b want 1", fl); end
    wait_redirect(w);
    checks++; if (w != 0) begin errors++; $display("[TB] FAIL cold_redir_latency: got %0d extra cycles want 0", w); end
    exp_pc = exp_redir_q.pop_front();
    checks++; if (redirect_pc !== exp_pc) begin errors++; $display("[TB] FAIL cold_redir_pc: got %h want %h", redirect_pc, exp_pc); end
    checks++; if (flush !== 1'b1) begin errors++; $display("[TB] FAIL cold_redir_flush: got %b want 1", flush); end
    @(posedge clk);
    #1;
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("[TB] FAIL cold_redir_done: got %b want 0", redirect_valid); end
    checks++; if (if_pred_taken !== 1'b1) begin errors++; $display("[TB] FAIL cold_refetch_pred: got %b want 1", if_pred_taken); end
    checks++; if (if_pred_target !== 32'h100) begin errors++; $display("[TB] FAIL cold_refetch_tgt: got %h want 100", if_pred_target); end
    checks++; if (stat_branches !== 32'(exp_branches)) begin errors++; $display("[TB] FAIL cold_branches: got %0d want %0d", stat_branches, exp_branches); end
    checks++; if (stat_mispredicts !== 32'(exp_mispredicts)) begin errors++; $display("[TB] FAIL cold_mispredicts: got %0d want %0d", stat_mispredicts, exp_mispredicts); end
  endtask

  // BEQ at 0x80 (same index as 0x40, different tag): T,T,T,NT,NT
  // counter walks 10,11,11,10,01
  task automatic test_beq_counter();
    logic [4:0] pt_t    = 5'b11110;
    logic [4:0] tk_t    = 5'b00111;
    logic [4:0] mp_t    = 5'b11001;
    logic [4:0] after_t = 5'b01111;
    logic fl;
    int w;
    logic [31:0] exp_pc;
    if_pc = 32'h80;
    for (int i = 0; i < 5; i++) begin
      resolve(32'h80, pt_t[i], pt_t[i] ? 32'h200 : 32'h0, 1'b1, 1'b1, tk_t[i], 32'h200, mp_t[i], fl);
      checks++; if (fl !== mp_t[i]) begin errors++; $display("[TB] FAIL beq_flush[%0d]: got %b want %b", i, fl, mp_t[i]); end
      if (mp_t[i]) begin
        wait_redirect(w);
        exp_pc = exp_redir_q.pop_front();
        checks++;
        if (!redirect_valid) begin
          errors++; $display("[TB] FAIL beq_redir_timeout[%0d]: got valid 0 want 1", i);
        end else if (redirect_pc !== exp_pc) begin
          errors++; $display("[TB] FAIL beq_redir_pc[%0d]: got %h want %h", i, redirect_pc, exp_pc);
        end
        @(posedge clk);
        #1;
      end else begin
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("[TB] FAIL beq_no_redir[%0d]: got %b want 0", i, redirect_valid); end
      end
      checks++; if (if_pred_taken !== after_t[i]) begin errors++; $display("[TB] FAIL beq_pred[%0d]: got %b want %b", i, if_pred_taken, after_t[i]); end
    end
    checks++; if (stat_branches !== 32'(exp_branches)) begin errors++; $display("[TB] FAIL beq_branches: got %0d want %0d", stat_branches, exp_branches); end
    checks++; if (stat_mispredicts !== 32'(exp_mispredicts)) begin errors++; $display("[TB] FAIL beq_mispredicts: got %0d want %0d", stat_mispredicts, exp_mispredicts); end
  endtask

  // J at 0xC4: cold to 0x200, then the target moves to 0x300
  task automatic test_target_change();
    logic [31:0] tgt_t [2];
    logic fl;
    int w;
    logic [31:0] exp_pc;
    tgt_t[0] = 32'h200;
    tgt_t[1] = 32'h300;
    if_pc = 32'hC4;
    for (int i = 0; i < 2; i++) begin
      resolve(32'hC4, (i == 1), (i == 1) ? 32'h200 : 32'h0, 1'b1, 1'b0, 1'b1, tgt_t[i], 1'b1, fl);
      checks++; if (fl !== 1'b1) begin errors++; $display("[TB] FAIL tgt_flush[%0d]: got %b want 1", i, fl); end
      wait_redirect(w);
      exp_pc = exp_redir_q.pop_front();
      checks++;
      if (!redirect_valid) begin
        errors++; $display("[TB] FAIL tgt_redir_timeout[%0d]: got valid 0 want 1", i);
      end else if (redirect_pc !== exp_pc) begin
        errors++; $display("[TB] FAIL tgt_redir_pc[%0d]: got %h want %h", i, redirect_pc, exp_pc);
      end
      @(posedge clk);
      #1;
      checks++; if (if_pred_target !== tgt_t[i]) begin errors++; $display("[TB] FAIL tgt_lookup[%0d]: got %h want %h", i, if_pred_target, tgt_t[i]); end
    end
    checks++; if (if_pred_taken !== 1'b1) begin errors++; $display("[TB] FAIL tgt_pred: got %b want 1", if_pred_taken); end
  endtask

  // Fetch holds off the redirect for three cycles
  task automatic test_ready_stall();
    logic fl;
    logic [31:0] exp_pc;
    redirect_ready = 1'b0;
    resolve(32'h108, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h400, 1'b1, fl);
    checks++; if (fl !== 1'b1) begin errors++; $display("[TB] FAIL stall_flush0: got %b want 1", fl); end
    exp_pc = exp_redir_q[0];
    for (int c = 0; c < 4; c++) begin
      if (c == 3) redirect_ready = 1'b1;
      checks++; if (redirect_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_rvalid[%0d]: got %b want 1", c, redirect_valid); end
      checks++; if (flush !== 1'b1) begin errors++; $display("[TB] FAIL stall_flush[%0d]: got %b want 1", c, flush); end
      checks++; if (redirect_pc !== exp_pc) begin errors++; $display("[TB] FAIL stall_rpc[%0d]: got %h want %h", c, redirect_pc, exp_pc); end
      @(posedge clk);
      #1;
    end
    void'(exp_redir_q.pop_front());
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_release_valid: got %b want 0", redirect_valid); end
    checks++; if (flush !== 1'b0) begin errors++; $display("[TB] FAIL stall_release_flush: got %b want 0", flush); end
  endtask

  // A non-branch whose PC matches a jump entry exactly
  task automatic test_alias();
    logic fl;
    int w;
    logic [31:0] exp_pc;
    if_pc = 32'h108;
    #1;
    checks++; if (if_pred_taken !== 1'b1) begin errors++; $display("[TB] FAIL alias_pre_pred: got %b want 1", if_pred_taken); end
    resolve(32'h108, 1'b1, 32'h400, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, fl);
    checks++; if (fl !== 1'b1) begin errors++; $display("[TB] FAIL alias_flush: got %b want 1", fl); end
    wait_redirect(w);
    exp_pc = exp_redir_q.pop_front();
    checks++;
    if (!redirect_valid) begin
      errors++; $display("[TB] FAIL alias_redir_timeout: got valid 0 want 1");
    end else if (redirect_pc !== exp_pc) begin
      errors++; $display("[TB] FAIL alias_redir_pc: got %h want %h", redirect_pc, exp_pc);
    end
    @(posedge clk);
    #1;
    checks++; if (if_pred_taken !== 1'b0) begin errors++; $display("[TB] FAIL alias_cleared: got %b want 0", if_pred_taken); end
    checks++; if (stat_branches !== 32'(exp_branches)) begin errors++; $display("[TB] FAIL alias_branches: got %0d want %0d", stat_branches, exp_branches); end
    checks++; if (stat_mispredicts !== 32'(exp_mispredicts)) begin errors++; $display("[TB] FAIL alias_mispredicts: got %0d want %0d", stat_mispredicts, exp_mispredicts); end
  endtask

  // A stalled EX instruction must not resolve
  task automatic test_ex_stall();
    ex_valid     = 1'b1;
    ex_stall     = 1'b1;
    ex_pc        = 32'h300;
    ex_npc       = 32'h304;
    ex_is_branch = 1'b1;
    ex_is_taken  = 1'b1;
    ex_target    = 32'h700;
    #2;
    checks++; if (flush !== 1'b0) begin errors++; $display("[TB] FAIL exstall_flush: got %b want 0", flush); end
    @(posedge clk);
    #1;
    idle_ex();
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("[TB] FAIL exstall_rvalid: got %b want 0", redirect_valid); end
    checks++; if (stat_branches !== 32'(exp_branches)) begin errors++; $display("[TB] FAIL exstall_branches: got %0d want %0d", stat_branches, exp_branches); end
  endtask

  // Reset while a redirect is pending drops it and empties the table
  task automatic test_reset_in_redir();
    logic [31:0] pcs [5];
    logic fl;
    pcs[0] = 32'h40; pcs[1] = 32'h80; pcs[2] = 32'hC4; pcs[3] = 32'h108; pcs[4] = 32'h200;
    redirect_ready = 1'b0;
    resolve(32'h200, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h500, 1'b1, fl);
    checks++; if (redirect_valid !== 1'b1) begin errors++; $display("[TB] FAIL rstredir_pending: got %b want 1", redirect_valid); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    redirect_ready = 1'b1;
    exp_redir_q.delete();
    exp_branches = 0;
    exp_mispredicts = 0;
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstredir_rvalid: got %b want 0", redirect_valid); end
    checks++; if (flush !== 1'b0) begin errors++; $display("[TB] FAIL rstredir_flush: got %b want 0", flush); end
    checks++; if (stat_branches !== 32'(exp_branches)) begin errors++; $display("[TB] FAIL rstredir_branches: got %0d want 0", stat_branches); end
    checks++; if (stat_mispredicts !== 32'(exp_mispredicts)) begin errors++; $display("[TB] FAIL rstredir_mispredicts: got %0d want 0", stat_mispredicts); end
    for (int i = 0; i < 5; i++) begin
      if_pc = pcs[i];
      #1;
      checks++; if (if_pred_taken !== 1'b0) begin errors++; $display("[TB] FAIL rstredir_pred[%h]: got %b want 0", pcs[i], if_pred_taken); end
    end
  endtask

  initial begin
    test_reset();
    test_cold_jump();
    test_beq_counter();
    test_target_change();
    test_ready_stall();
    test_alias();
    test_ex_stall();
    test_reset_in_redir();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
